xadc_channel_analyzer: RTL and testbench

Parametrised successor to the fixed four-channel XADC reader in the neuromorphic ASIC bridge. Once per XADC end-of-sequence it sweeps `NUM_CHANNELS` auxiliary result registers over the DRP and block-averages each channel over 2^`AVG_LOG2` sweeps. It then picks the winning channel (argmax, gated by a programmable threshold) as `network_output`. It sits between the XADC primitive and `axi_cfg_regs` / the LED logic in the bridge top level.

---
 rtl/xadc_analyzer_pkg.sv | 22 ++
 rtl/xadc_channel_analyzer_argmax.sv | 34 +++
 rtl/xadc_channel_analyzer.sv | 162 ++++++++++++++++
 tb/tb_xadc_channel_analyzer.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_analyzer_pkg.sv
// Shared definitions for the XADC channel analyzer slice.
//   state_t    : sweep/decide FSM states
//   AUX0_ADDR  : DRP address of the first auxiliary result register
//   idx_width  : bit width needed to index n channels (never below 1)
package xadc_analyzer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_EOS,
    ST_ISSUE,
    ST_WAIT_DRDY,
    ST_SWEEP_DONE,
    ST_DECIDE
  } state_t;

  localparam logic [6:0] AUX0_ADDR = 7'h10;

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/xadc_channel_analyzer_argmax.sv
// channel_argmax: combinational compare chain over NUM_CHANNELS packed values.
//   values          in  : channel k at [k*ADC_WIDTH +: ADC_WIDTH]
//   threshold       in  : minimum value a winner must reach
//   max_idx         out : index of the largest value (lowest index on ties)
//   max_value       out : the largest value
//   below_threshold out : max_value < threshold
module channel_argmax
  import xadc_analyzer_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int ADC_WIDTH    = 12,
  localparam int IDX_W       = idx_width(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS*ADC_WIDTH-1:0] values,
  input  logic [ADC_WIDTH-1:0]              threshold,
  output logic [IDX_W-1:0]                  max_idx,
  output logic [ADC_WIDTH-1:0]              max_value,
  output logic                              below_threshold
);

  // Strict greater-than keeps the earliest channel when values tie.
  always_comb begin
    max_idx   = '0;
    max_value = values[ADC_WIDTH-1:0];
    for (int k = 1; k < NUM_CHANNELS; k++) begin
      if (values[k*ADC_WIDTH +: ADC_WIDTH] > max_value) begin
        max_value = values[k*ADC_WIDTH +: ADC_WIDTH];
        max_idx   = IDX_W'(k);
      end
    end
    below_threshold = (max_value < threshold);
  end

endmodule

// File: rtl/xadc_channel_analyzer.sv
// xadc_channel_analyzer: on each XADC end-of-sequence, reads NUM_CHANNELS aux
// result registers over the DRP, block-averages each over 2^AVG_LOG2 sweeps and
// reports the thresholded argmax channel.
//   clk, rst           : single clock (also DCLK), synchronous active-high reset
//   enable, eos        : sweep enable (sampled in IDLE), XADC EOS pulse
//   threshold          : minimum averaged value for a winner
//   daddr/den/dwe/di   : DRP request side (read only, dwe/di tied 0)
//   do_data/drdy       : DRP response side
//   measured           : averaged results, channel k at [k*ADC_WIDTH +: ADC_WIDTH]
//   network_output     : winning channel index
//   no_winner          : last decision's maximum was below threshold
//   result_valid       : one-cycle pulse when results update
//   drp_error          : sticky DRDY timeout flag
module xadc_channel_analyzer
  import xadc_analyzer_pkg::*;
#(
  parameter int         NUM_CHANNELS   = 4,
  parameter int         ADC_WIDTH      = 12,
  parameter logic [6:0] FIRST_AUX_ADDR = AUX0_ADDR,
  parameter int         AVG_LOG2       = 2,
  parameter int         DRDY_TIMEOUT   = 255,
  localparam int        IDX_W          = idx_width(NUM_CHANNELS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [ADC_WIDTH-1:0]              threshold,
  input  logic                              eos,
  output logic [6:0]                        daddr,
  output logic                              den,
  output logic                              dwe,
  output logic [15:0]                       di,
  input  logic [15:0]                       do_data,
  input  logic                              drdy,
  output logic [NUM_CHANNELS*ADC_WIDTH-1:0] measured,
  output logic [IDX_W-1:0]                  network_output,
  output logic                              no_winner,
  output logic                              result_valid,
  output logic                              drp_error
);

  localparam int ACC_W   = ADC_WIDTH + AVG_LOG2;
  localparam int SWEEP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int TO_W    = (DRDY_TIMEOUT < 1) ? 1 : $clog2(DRDY_TIMEOUT + 1);

  state_t state, next_state;

  logic [ACC_W-1:0]                  acc [NUM_CHANNELS];
  logic [IDX_W-1:0]                  ch;
  logic [IDX_W-1:0]                  issue_ch;
  logic [SWEEP_W-1:0]                sweep_cnt;
  logic [TO_W-1:0]                   to_cnt;
  logic [ADC_WIDTH-1:0]              sample;
  logic [NUM_CHANNELS*ADC_WIDTH-1:0] averaged;
  logic [IDX_W-1:0]                  win_idx;
  logic [ADC_WIDTH-1:0]              win_value;
  logic                              win_below;
  logic                              last_ch;
  logic                              last_sweep;
  logic                              timeout_hit;

  assign dwe = 1'b0;
  assign di  = 16'h0000;

  // The XADC left-justifies its results inside the 16-bit DRP word.
  assign sample      = do_data[15 -: ADC_WIDTH];
  assign last_ch     = (ch == IDX_W'(NUM_CHANNELS - 1));
  assign last_sweep  = (sweep_cnt == SWEEP_W'((1 << AVG_LOG2) - 1));
  assign timeout_hit = (to_cnt == TO_W'(DRDY_TIMEOUT));

  // ISSUE is entered either from WAIT_EOS (channel 0) or after a completed read.
  assign issue_ch = (state == ST_WAIT_EOS) ? '0 : ch + 1'b1;

  // Truncating divide of every accumulator by the window length.
  always_comb begin
    averaged = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      averaged[k*ADC_WIDTH +: ADC_WIDTH] = ADC_WIDTH'(acc[k] >> AVG_LOG2);
    end
  end

  channel_argmax #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .ADC_WIDTH    (ADC_WIDTH)
  ) u_argmax (
    .values          (averaged),
    .threshold       (threshold),
    .max_idx         (win_idx),
    .max_value       (win_value),
    .below_threshold (win_below)
  );

  // Next-state logic; drdy beats a timeout landing in the same cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:       if (enable) next_state = ST_WAIT_EOS;
      ST_WAIT_EOS:   if (eos) next_state = ST_ISSUE;
      ST_ISSUE:      next_state = ST_WAIT_DRDY;
      ST_WAIT_DRDY: begin
        if (drdy)             next_state = last_ch ? ST_SWEEP_DONE : ST_ISSUE;
        else if (timeout_hit) next_state = ST_IDLE;
      end
      ST_SWEEP_DONE: next_state = last_sweep ? ST_DECIDE : ST_IDLE;
      ST_DECIDE:     next_state = ST_IDLE;
      default:       next_state = ST_IDLE;
    endcase
  end

  // State register, DRP request registers and the averaging datapath.
  // den/daddr are loaded on the edge that enters ISSUE so both are valid for
  // the whole ISSUE cycle; daddr then holds until the next ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      daddr          <= '0;
      den            <= 1'b0;
      measured       <= '0;
      network_output <= '0;
      no_winner      <= 1'b1;
      result_valid   <= 1'b0;
      drp_error      <= 1'b0;
      ch             <= '0;
      sweep_cnt      <= '0;
      to_cnt         <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) acc[k] <= '0;
    end else begin
      state        <= next_state;
      den          <= (next_state == ST_ISSUE);
      result_valid <= 1'b0;
      if (next_state == ST_ISSUE) daddr <= FIRST_AUX_ADDR + 7'(issue_ch);

      case (state)
        ST_WAIT_EOS: if (eos) ch <= '0;
        ST_ISSUE:    to_cnt <= '0;
        ST_WAIT_DRDY: begin
          if (drdy) begin
            acc[ch] <= acc[ch] + ACC_W'(sample);
            if (!last_ch) ch <= ch + 1'b1;
          end else if (timeout_hit) begin
            drp_error <= 1'b1;
            sweep_cnt <= '0;
            for (int k = 0; k < NUM_CHANNELS; k++) acc[k] <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        ST_SWEEP_DONE: if (!last_sweep) sweep_cnt <= sweep_cnt + 1'b1;
        ST_DECIDE: begin
          measured     <= averaged;
          no_winner    <= win_below;
          result_valid <= 1'b1;
          if (!win_below) network_output <= win_idx;
          sweep_cnt    <= '0;
          for (int k = 0; k < NUM_CHANNELS; k++) acc[k] <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_xadc_channel_analyzer.sv
// Self-checking bench for xadc_channel_analyzer: a default 4-channel instance
// (dut_a) and an 8-channel, no-averaging instance (dut_b), each fed by a DRP
// responder and checked against a window-average / argmax model.
module tb_xadc_channel_analyzer;

  localparam int NA = 4;
  localparam int NB = 8;
  localparam int W  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, enable;
  logic [W-1:0] threshold;

  logic            eos_a, den_a, dwe_a, drdy_a, rv_a, nw_a, err_a;
  logic [6:0]      daddr_a;
  logic [15:0]     di_a, do_a;
  logic [NA*W-1:0] meas_a;
  logic [1:0]      net_a;

  logic            eos_b, den_b, dwe_b, drdy_b, rv_b, nw_b, err_b;
  logic [6:0]      daddr_b;
  logic [15:0]     di_b, do_b;
  logic [NB*W-1:0] meas_b;
  logic [2:0]      net_b;

  xadc_channel_analyzer dut_a (
    .clk(clk), .rst(rst), .enable(enable), .threshold(threshold), .eos(eos_a),
    .daddr(daddr_a), .den(den_a), .dwe(dwe_a), .di(di_a), .do_data(do_a),
    .drdy(drdy_a), .measured(meas_a), .network_output(net_a),
    .no_winner(nw_a), .result_valid(rv_a), .drp_error(err_a)
  );

  xadc_channel_analyzer #(.NUM_CHANNELS(NB), .AVG_LOG2(0)) dut_b (
    .clk(clk), .rst(rst), .enable(enable), .threshold(threshold), .eos(eos_b),
    .daddr(daddr_b), .den(den_b), .dwe(dwe_b), .di(di_b), .do_data(do_b),
    .drdy(drdy_b), .measured(meas_b), .network_output(net_b),
    .no_winner(nw_b), .result_valid(rv_b), .drp_error(err_b)
  );

  int checks_total  = 0;
  int checks_passed = 0;

  // Single comparison point: every check funnels through here.
  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic [NA*W-1:0] meas;
    logic [1:0]      net;
    logic            nw;
  } exp_a_t;
  typedef struct packed {
    logic [NB*W-1:0] meas;
    logic [2:0]      net;
    logic            nw;
  } exp_b_t;

  logic [W-1:0] vals_a [NA];
  logic [W-1:0] vals_b [NB];
  int unsigned  sum_a [NA];
  int           win_cnt_a   = 0;
  int           model_net_a = 0;
  int           model_net_b = 0;
  exp_a_t       q_a [$];
  exp_b_t       q_b [$];

  task automatic model_clear_a();
    for (int k = 0; k < NA; k++) sum_a[k] = 0;
    win_cnt_a = 0;
  endtask

  // A decision is due every 4th sweep: mean (floored), first maximum, threshold gate.
  task automatic model_sweep_a();
    int unsigned avg [NA];
    int best;
    exp_a_t e;
    for (int k = 0; k < NA; k++) sum_a[k] += vals_a[k];
    win_cnt_a++;
    if (win_cnt_a == 4) begin
      best = 0;
      for (int k = 0; k < NA; k++) avg[k] = sum_a[k] / 4;
      for (int k = 1; k < NA; k++) if (avg[k] > avg[best]) best = k;
      e.nw = (avg[best] < threshold);
      if (!e.nw) model_net_a = best;
      e.net = 2'(model_net_a);
      for (int k = 0; k < NA; k++) e.meas[k*W +: W] = W'(avg[k]);
      q_a.push_back(e);
      model_clear_a();
    end
  endtask

  task automatic model_sweep_b();
    int best;
    exp_b_t e;
    best = 0;
    for (int k = 1; k < NB; k++) if (vals_b[k] > vals_b[best]) best = k;
    e.nw = (vals_b[best] < threshold);
    if (!e.nw) model_net_b = best;
    e.net = 3'(model_net_b);
    for (int k = 0; k < NB; k++) e.meas[k*W +: W] = vals_b[k];
    q_b.push_back(e);
  endtask

  // ---------------- DRP responders ----------------
  int       lat_a = 2, lat_b = 1;
  bit       respond_a = 1'b1;
  int       reads_a = 0, reads_b = 0;
  logic [6:0] addr_q_b [$];

  initial begin
    int ch;
    drdy_a = 1'b0; do_a = '0;
    forever begin
      @(negedge clk);
      drdy_a = 1'b0;
      if (den_a === 1'b1 && respond_a) begin
        ch = int'(daddr_a) - 16;
        if (ch < 0 || ch >= NA) ch = 0;
        repeat (lat_a) @(negedge clk);
        drdy_a = 1'b1;
        do_a   = {vals_a[ch], 4'hA};
        reads_a++;
      end
    end
  end

  initial begin
    int ch;
    drdy_b = 1'b0; do_b = '0;
    forever begin
      @(negedge clk);
      drdy_b = 1'b0;
      if (den_b === 1'b1) begin
        addr_q_b.push_back(daddr_b);
        ch = int'(daddr_b) - 16;
        if (ch < 0 || ch >= NB) ch = 0;
        repeat (lat_b) @(negedge clk);
        drdy_b = 1'b1;
        do_b   = {vals_b[ch], 4'h5};
        reads_b++;
      end
    end
  end

  // ---------------- compare process ----------------
  logic den_a_prev = 1'b0, den_b_prev = 1'b0;
  always @(negedge clk) begin
    exp_a_t ea;
    exp_b_t eb;
    if (rv_a === 1'b1) begin
      if (q_a.size() == 0) checkOutput("rv_a_unexpected", 1, 0);
      else begin
        ea = q_a.pop_front();
        checkOutput("model_meas_a", meas_a, ea.meas);
        checkOutput("model_net_a", net_a, ea.net);
        checkOutput("model_nw_a", nw_a, ea.nw);
      end
    end
    if (rv_b === 1'b1) begin
      if (q_b.size() == 0) checkOutput("rv_b_unexpected", 1, 0);
      else begin
        eb = q_b.pop_front();
        checkOutput("model_meas_b", meas_b, eb.meas);
        checkOutput("model_net_b", net_b, eb.net);
        checkOutput("model_nw_b", nw_b, eb.nw);
      end
    end
    if (den_a === 1'b1) begin
      checkOutput("den_a_single_cycle", den_a_prev, 0);
      checkOutput("dwe_di_a", {dwe_a, di_a}, 0);
    end
    if (den_b === 1'b1) checkOutput("den_b_single_cycle", den_b_prev, 0);
    den_a_prev <= den_a;
    den_b_prev <= den_b;
  end

  // ---------------- stimulus ----------------
  task automatic set_a(input logic [W-1:0] v0, v1, v2, v3);
    vals_a[0] = v0; vals_a[1] = v1; vals_a[2] = v2; vals_a[3] = v3;
  endtask

  // One sweep on the selected instance: update the model, pulse eos, wait for
  // all channel reads, then let the FSM return to WAIT_EOS.
  task automatic applyStimulus(input int dut_sel);
    int start, budget;
    budget = 0;
    if (dut_sel == 0) begin
      start = reads_a;
      model_sweep_a();
      eos_a = 1'b1; @(negedge clk); eos_a = 1'b0;
      while (reads_a < start + NA && budget < 200) begin @(negedge clk); budget++; end
      checkOutput("reads_a", 128'(reads_a - start), 128'(NA));
    end else begin
      start = reads_b;
      addr_q_b.delete();
      model_sweep_b();
      eos_b = 1'b1; @(negedge clk); eos_b = 1'b0;
      while (reads_b < start + NB && budget < 200) begin @(negedge clk); budget++; end
      checkOutput("reads_b", 128'(reads_b - start), 128'(NB));
      if (addr_q_b.size() == NB)
        for (int i = 0; i < NB; i++) checkOutput("daddr_b_step", addr_q_b[i], 128'(16 + i));
      else checkOutput("daddr_b_count", addr_q_b.size(), NB);
    end
    repeat (5) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n, budget;
    rst = 1'b1; enable = 1'b0; threshold = '0; eos_a = 1'b0; eos_b = 1'b0;
    model_clear_a();
    set_a(0, 0, 0, 0);
    for (int k = 0; k < NB; k++) vals_b[k] = '0;
    repeat (3) @(negedge clk);

    $display("[TB] reset values");
    checkOutput("rst_meas_a", meas_a, 0);
    checkOutput("rst_net_a", net_a, 0);
    checkOutput("rst_nw_a", nw_a, 1);
    checkOutput("rst_rv_a", rv_a, 0);
    checkOutput("rst_err_a", err_a, 0);
    checkOutput("rst_den_daddr_a", {den_a, daddr_a}, 0);
    rst = 1'b0; enable = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] basic average");
    set_a(12'h100, 12'h200, 12'h800, 12'h300);
    repeat (4) applyStimulus(0);
    checkOutput("basic_meas", meas_a, 48'h300_800_200_100);
    checkOutput("basic_net", net_a, 2);
    checkOutput("basic_nw", nw_a, 0);

    $display("[TB] tie picks lower index");
    set_a(12'h100, 12'h7FF, 12'h050, 12'h7FF);
    repeat (4) applyStimulus(0);
    checkOutput("tie_net", net_a, 1);
    checkOutput("tie_meas", meas_a, 48'h7FF_050_7FF_100);

    $display("[TB] threshold gate");
    threshold = 12'h900;
    set_a(12'h7FF, 12'h100, 12'h200, 12'h300);
    repeat (4) applyStimulus(0);
    checkOutput("thr_nw", nw_a, 1);
    checkOutput("thr_net_kept", net_a, 1);
    checkOutput("thr_meas", meas_a, 48'h300_200_100_7FF);
    threshold = '0;

    $display("[TB] truncation");
    set_a(12'h001, 12'h010, 12'h004, 12'h000);
    repeat (3) applyStimulus(0);
    set_a(12'h002, 12'h010, 12'h004, 12'h000);
    applyStimulus(0);
    checkOutput("trunc_meas", meas_a, 48'h000_004_010_001);
    checkOutput("trunc_net", net_a, 1);

    $display("[TB] drdy timeout");
    checkOutput("err_before_timeout", err_a, 0);
    set_a(12'h111, 12'h222, 12'h333, 12'h444);
    repeat (2) applyStimulus(0);
    respond_a = 1'b0;
    eos_a = 1'b1; @(negedge clk); eos_a = 1'b0;
    budget = 0;
    while (den_a !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
    n = 0;
    while (err_a !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    checkOutput("timeout_latency", n, 257);
    model_clear_a();
    respond_a = 1'b1;
    repeat (5) @(negedge clk);
    set_a(12'h020, 12'h040, 12'h030, 12'h010);
    repeat (4) applyStimulus(0);
    checkOutput("post_timeout_meas", meas_a, 48'h010_030_040_020);
    checkOutput("err_sticky", err_a, 1);

    $display("[TB] reset during read");
    lat_a = 6;
    eos_a = 1'b1; @(negedge clk); eos_a = 1'b0;
    budget = 0;
    while (den_a !== 1'b1 && budget < 20) begin @(negedge clk); budget++; end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_den", den_a, 0);
    checkOutput("midrst_meas", meas_a, 0);
    checkOutput("midrst_net_nw", {net_a, nw_a}, 3'b001);
    checkOutput("midrst_err", err_a, 0);
    rst = 1'b0;
    model_clear_a();
    model_net_a = 0;
    repeat (10) @(negedge clk);
    checkOutput("late_drdy_den", den_a, 0);
    checkOutput("late_drdy_meas", meas_a, 0);
    lat_a = 2;
    set_a(12'hABC, 12'h123, 12'h456, 12'h789);
    repeat (4) applyStimulus(0);
    checkOutput("post_rst_meas", meas_a, 48'h789_456_123_ABC);
    checkOutput("post_rst_net", net_a, 0);

    $display("[TB] eight channels, no averaging");
    for (int k = 0; k < NB; k++) vals_b[k] = W'(k + 1);
    vals_b[5] = 12'hFFF;
    applyStimulus(1);
    checkOutput("b_meas", meas_b, 96'h008_007_FFF_005_004_003_002_001);
    checkOutput("b_net", net_b, 5);
    for (int k = 0; k < NB; k++) vals_b[k] = 12'h100;
    vals_b[5] = 12'hFFF;
    vals_b[7] = 12'hFFF;
    applyStimulus(1);
    checkOutput("b_tie_net", net_b, 5);
    checkOutput("b_nw", nw_b, 0);

    repeat (5) @(negedge clk);
    checkOutput("q_a_drained", q_a.size(), 0);
    checkOutput("q_b_drained", q_b.size(), 0);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
